// File: rtl/riscv_fetch_pkg.sv
// Shared constants and fetch state type for the instruction fetch unit.
package riscv_fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INST_BYTES   = 4;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO for fetched {inst, pc} entries; the head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Flush wins over a same-cycle push or pop.
    assign push_en = push && !flush;
    assign pop_en  = pop && !flush && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(push_en && full));
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one-outstanding imem requests, buffered valid/ready stream, redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_killed counters.
//
// state | meaning
// REQ   | may issue a request at pc when buffer space allows
// WAIT  | one request outstanding; kill=1 means its response is discarded
module instr_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] op_value,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              in_flight, req_fire, resp_fire;

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data ({imem_resp_data, req_pc_q}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Buffered plus outstanding words never exceed the FIFO, so a push always finds room.
    assign in_flight      = (state_q == WAIT);
    assign imem_req_valid = !rst && (state_q == REQ) && !fifo_full &&
                            (({1'b0, fifo_count} + (AW+2)'(in_flight)) < (AW+2)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_fire      = (state_q == WAIT) && imem_resp_valid;

    assign op_value   = fifo_head[2*XLEN-1:XLEN];
    assign inst_pc    = fifo_head[XLEN-1:0];
    assign inst_valid = !fifo_empty;
    assign fifo_pop   = inst_valid && inst_ready;
    assign fifo_flush = redirect_valid;
    assign fifo_push  = resp_fire && !kill_q && !redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(INST_BYTES - 1);
            // A response landing with the redirect is dropped here and needs no kill.
            if (state_q == WAIT) begin
                kill_d = !imem_resp_valid;
            end else begin
                kill_d = req_fire;
            end
            state_d = kill_d ? WAIT : REQ;
        end else begin
            case (state_q)
                REQ: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(INST_BYTES);
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_killed_q, perf_killed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(fifo_push);
        perf_killed_d  = perf_killed_q + 32'(resp_fire && (kill_q || redirect_valid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_killed_q  <= perf_killed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences, random traffic vs stream model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] op_value;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .op_value        (op_value),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_killed     (perf_killed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rq_rdy;
        logic        rs_vld;
        logic [31:0] rs_data;
        logic        i_rdy;
        logic        rd_vld;
        logic [31:0] rd_pc;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ip;
        logic [31:0] e_op;
    } vec_t;

    vec_t tbl [16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic drive(input logic rq_rdy, input logic rs_vld, input logic [31:0] rs_data,
                         input logic i_rdy, input logic rd_vld, input logic [31:0] rd_pc);
        imem_req_ready  = rq_rdy;
        imem_resp_valid = rs_vld;
        imem_resp_data  = rs_data;
        inst_ready      = i_rdy;
        redirect_valid  = rd_vld;
        redirect_pc     = rd_pc;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Random-phase reference: the decoder sees a sequential PC stream restarting at each redirect target.
    logic [31:0] exp_req_pc, exp_inst_pc, mem_addr;
    logic        mem_pending;
    int          mem_delay;
    int          pops;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h13, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h13};
        tbl[3]  = '{1'b1, 1'b1, 32'h13, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h13};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[9]  = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
        tbl[11] = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
        tbl[13] = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h13};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0};

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_valid", 32'(imem_req_valid), 32'd0);
        check("reset inst_valid", 32'(inst_valid), 32'd0);
        check("reset op_value", op_value, 32'h0);
        check("reset inst_pc", inst_pc, 32'h0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rq_rdy, tbl[i].rs_vld, tbl[i].rs_data, tbl[i].i_rdy, tbl[i].rd_vld, tbl[i].rd_pc);
            check($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_ra);
            check($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_ip);
                check($sformatf("vec%0d op_value", i), op_value, tbl[i].e_op);
            end
            next_cycle();
        end

`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd3);
        check("perf_killed", perf_killed, 32'd2);
`endif

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wrap first addr", imem_req_addr, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b1, 1'b1, 32'hDEAD_0013, 1'b0, 1'b0, 32'h0);
        check("wrap wait req_valid", 32'(imem_req_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap next req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap next addr", imem_req_addr, 32'h0);
        check("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap op_value", op_value, 32'hDEAD_0013);
        next_cycle();

        // Request accepted in the redirect cycle is killed; buffered word is flushed.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        check("kill accept req_valid", 32'(imem_req_valid), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("kill wait req_valid", 32'(imem_req_valid), 32'd0);
        check("kill flushed", 32'(inst_valid), 32'd0);
        next_cycle();
        drive(1'b1, 1'b1, 32'hBAD0_0013, 1'b0, 1'b0, 32'h0);
        check("kill resp req_valid", 32'(imem_req_valid), 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("kill target addr", imem_req_addr, 32'h200);
        check("kill discarded", 32'(inst_valid), 32'd0);
        next_cycle();

        // Reset with a request outstanding; the late response must be ignored.
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rst req_valid", 32'(imem_req_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        check("post rst addr", imem_req_addr, 32'h0);
        check("post rst req_valid", 32'(imem_req_valid), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("post rst stale ignored", 32'(inst_valid), 32'd0);
        next_cycle();

        exp_req_pc  = 32'h0;
        exp_inst_pc = 32'h0;
        mem_pending = 1'b0;
        mem_addr    = '0;
        mem_delay   = 0;
        pops        = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            if (mem_pending && mem_delay == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(mem_addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            @(negedge clk);
            if (imem_resp_valid) mem_pending = 1'b0;
            else if (mem_pending) mem_delay--;
            if (imem_req_valid && imem_req_ready) begin
                check("rand one outstanding", 32'(mem_pending), 32'd0);
                check("rand req_addr", imem_req_addr, exp_req_pc);
                exp_req_pc  = exp_req_pc + 32'd4;
                mem_pending = 1'b1;
                mem_addr    = imem_req_addr;
                mem_delay   = $urandom_range(0, 2);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                check("rand inst_pc", inst_pc, exp_inst_pc);
                check("rand op_value", op_value, word_of(exp_inst_pc));
                exp_inst_pc = exp_inst_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) begin
                exp_req_pc  = redirect_pc & ~32'h3;
                exp_inst_pc = redirect_pc & ~32'h3;
            end
            next_cycle();
        end
        check("rand progress", 32'(pops > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
